// File: rtl/lamp_fpu_sqrt_iter.sv
// Radix-2 restoring square root / inverse square root for lampFPU, one result bit per cycle.
// Optional macro LAMP_FPU_SQRT_EXACT_FLAG_EN adds the isExact_o output.
module lamp_fpu_sqrt_iter #(
  parameter int E_DW = 8,
  parameter int F_DW = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              invSqrt_i,
  input  logic              signum_i,
  input  logic [E_DW-1:0]   extExp_i,
  input  logic [F_DW:0]     extMant_i,
  input  logic              isZero_i,
  input  logic              isInf_i,
  input  logic              isSNAN_i,
  input  logic              isQNAN_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              s_res_o,
  output logic [E_DW-1:0]   e_res_o,
  output logic [F_DW+4:0]   f_res_o,
  output logic              isToRound_o,
  output logic              busy_o
`ifdef LAMP_FPU_SQRT_EXACT_FLAG_EN
  ,output logic             isExact_o
`endif
);

  localparam int NR = F_DW + 3;
  localparam int RW = NR + 3;
  localparam int XW = 2 * NR;
  localparam int CW = $clog2(NR);
  localparam logic [E_DW-1:0] BIAS = E_DW'((1 << (E_DW - 1)) - 1);
  localparam logic [CW-1:0]   LAST = CW'(NR - 1);
  localparam logic [NR-1:0]   ONE_ROOT = NR'(1) << (NR - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SQRT, DIV, PACK, SPECIAL, DONE} state_t;

  state_t            state_q, state_d;
  logic              inv_q, inv_d, sgn_q, sgn_d;
  logic              nan_q, nan_d, zero_q, zero_d;
  logic [E_DW-1:0]   ehalf_q, ehalf_d;
  logic [XW-1:0]     rad_q, rad_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [NR-1:0]     root_q, root_d, quo_q, quo_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              root_exact_q, root_exact_d;
  logic              valid_q, valid_d, s_res_q, s_res_d, round_q, round_d;
  logic [E_DW-1:0]   e_res_q, e_res_d;
  logic [F_DW+4:0]   f_res_q, f_res_d;
`ifdef LAMP_FPU_SQRT_EXACT_FLAG_EN
  logic              exact_q, exact_d;
`endif

  logic              in_zero, in_nan, in_special;
  logic [E_DW:0]     u_ext;
  logic [XW-1:0]     radicand;
  logic [RW-1:0]     sq_rem_sh, sq_trial, sq_rem_nxt, dv_t, dv_rem_nxt;
  logic [NR-1:0]     sq_root_nxt;
  logic              sq_ge, dv_ge;

  // Subnormals flush to zero; a negative nonzero operand is folded into the NaN class.
  assign in_zero    = isZero_i | (~extMant_i[F_DW] & (extExp_i == '0));
  assign in_nan     = isSNAN_i | isQNAN_i | (signum_i & ~in_zero);
  assign in_special = in_nan | in_zero | isInf_i;
  assign u_ext      = {1'b0, extExp_i} - {1'b0, BIAS};
  assign radicand   = u_ext[0] ? {extMant_i, {(XW-F_DW-1){1'b0}}}
                               : {1'b0, extMant_i, {(XW-F_DW-2){1'b0}}};

  assign sq_rem_sh   = (rem_q << 2) | RW'(rad_q[XW-1 -: 2]);
  assign sq_trial    = {1'b0, root_q, 2'b01};
  assign sq_ge       = (sq_rem_sh >= sq_trial);
  assign sq_rem_nxt  = sq_ge ? (sq_rem_sh - sq_trial) : sq_rem_sh;
  assign sq_root_nxt = {root_q[NR-2:0], sq_ge};
  assign dv_t        = rem_q << 1;
  assign dv_ge       = (dv_t >= RW'(root_q));
  assign dv_rem_nxt  = dv_ge ? (dv_t - RW'(root_q)) : dv_t;

  always_comb begin
    state_d = state_q;  inv_d = inv_q;  sgn_d = sgn_q;  nan_d = nan_q;  zero_d = zero_q;
    ehalf_d = ehalf_q;  rad_d = rad_q;  rem_d = rem_q;  root_d = root_q;  quo_d = quo_q;
    cnt_d = cnt_q;  root_exact_d = root_exact_q;  valid_d = valid_q;  s_res_d = s_res_q;
    e_res_d = e_res_q;  f_res_d = f_res_q;  round_d = round_q;
`ifdef LAMP_FPU_SQRT_EXACT_FLAG_EN
    exact_d = exact_q;
`endif
    case (state_q)
      IDLE: if (valid_i) begin
        inv_d = invSqrt_i;  sgn_d = signum_i;  nan_d = in_nan;  zero_d = in_zero;
        ehalf_d = u_ext[E_DW:1];  rad_d = radicand;
        rem_d = '0;  root_d = '0;  quo_d = '0;  cnt_d = '0;  root_exact_d = 1'b0;
        state_d = in_special ? SPECIAL : LOAD;
      end
      // LOAD retires the first root bit, so the sqrt phase spans LOAD plus NR-1 SQRT cycles.
      LOAD, SQRT: begin
        rem_d = sq_rem_nxt;  root_d = sq_root_nxt;  rad_d = rad_q << 2;  cnt_d = cnt_q + 1'b1;
        if (state_q == LOAD) begin
          state_d = SQRT;
        end else if (cnt_q == LAST) begin
          if (inv_q) begin
            root_exact_d = (sq_rem_nxt == '0) && (sq_root_nxt == ONE_ROOT);
            rem_d = RW'(ONE_ROOT);
            cnt_d = '0;
            state_d = DIV;
          end else begin
            state_d = PACK;
          end
        end
      end
      DIV: begin
        rem_d = dv_rem_nxt;  quo_d = {quo_q[NR-2:0], dv_ge};  cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = PACK;
      end
      PACK: begin
        s_res_d = 1'b0;  round_d = 1'b1;  valid_d = 1'b1;  state_d = DONE;
        if (!inv_q) begin
          e_res_d = BIAS + ehalf_q;
          f_res_d = {1'b0, root_q, |rem_q};
        end else if (root_exact_q) begin
          e_res_d = BIAS - ehalf_q;
          f_res_d = {2'b01, {NR{1'b0}}};
        end else begin
          e_res_d = BIAS - ehalf_q - 1'b1;
          f_res_d = {1'b0, quo_q, |rem_q};
        end
`ifdef LAMP_FPU_SQRT_EXACT_FLAG_EN
        exact_d = inv_q ? root_exact_q : (rem_q == '0);
`endif
      end
      SPECIAL: begin
        round_d = 1'b0;  valid_d = 1'b1;  f_res_d = '0;  state_d = DONE;
        if (nan_q) begin
          s_res_d = 1'b0;  e_res_d = '1;  f_res_d = (F_DW+5)'(1) << (F_DW + 2);
        end else if (zero_q) begin
          s_res_d = sgn_q;  e_res_d = inv_q ? '1 : '0;
        end else begin
          s_res_d = 1'b0;  e_res_d = inv_q ? '0 : '1;
        end
`ifdef LAMP_FPU_SQRT_EXACT_FLAG_EN
        exact_d = ~nan_q;
`endif
      end
      DONE: if (ready_i) begin
        valid_d = 1'b0;  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;  inv_q <= 1'b0;  sgn_q <= 1'b0;  nan_q <= 1'b0;  zero_q <= 1'b0;
      ehalf_q <= '0;  rad_q <= '0;  rem_q <= '0;  root_q <= '0;  quo_q <= '0;  cnt_q <= '0;
      root_exact_q <= 1'b0;  valid_q <= 1'b0;  s_res_q <= 1'b0;  e_res_q <= '0;
      f_res_q <= '0;  round_q <= 1'b0;
`ifdef LAMP_FPU_SQRT_EXACT_FLAG_EN
      exact_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;  inv_q <= inv_d;  sgn_q <= sgn_d;  nan_q <= nan_d;  zero_q <= zero_d;
      ehalf_q <= ehalf_d;  rad_q <= rad_d;  rem_q <= rem_d;  root_q <= root_d;  quo_q <= quo_d;
      cnt_q <= cnt_d;  root_exact_q <= root_exact_d;  valid_q <= valid_d;  s_res_q <= s_res_d;
      e_res_q <= e_res_d;  f_res_q <= f_res_d;  round_q <= round_d;
`ifdef LAMP_FPU_SQRT_EXACT_FLAG_EN
      exact_q <= exact_d;
`endif
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign valid_o     = valid_q;
  assign s_res_o     = s_res_q;
  assign e_res_o     = e_res_q;
  assign f_res_o     = f_res_q;
  assign isToRound_o = round_q;
`ifdef LAMP_FPU_SQRT_EXACT_FLAG_EN
  assign isExact_o   = exact_q;
`endif

endmodule
